// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings, FSM states and per-state control word for the multicycle CPU
package cpu_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.alusrca = 1'b1; c.alusrcb = SRCB_4; c.resultsrc = RES_ALU; end
            DECODE:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_4; c.resultsrc = RES_ALU; end
            MEMADR:   c.alusrcb = SRCB_IMM;
            MEMRD:    c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = RES_RDATA; c.regw = 1'b1; end
            MEMWR:    begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECUTER: c.aluop = 1'b1;
            EXECUTEI: begin c.alusrcb = SRCB_IMM; c.aluop = 1'b1; end
            ALUWB:    c.regw = 1'b1;
            BRANCH:   begin c.alusrcb = SRCB_IMM; c.resultsrc = RES_ALU; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/mc_decoder_if.sv
// mc_decoder_if: instruction fields in, control strobes and datapath selects out
interface mc_decoder_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    modport master (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: Moore sequencer; the control word is registered alongside the state
module mc_main_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] op,
    input  logic       imm,
    input  logic       ld,
    output ctrl_t      ctrl
);
    state_t state, nxt;

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:              nxt = DECODE;
            DECODE:             nxt = op == OP_MEM ? MEMADR :
                                      op == OP_BR  ? BRANCH :
                                      op == OP_DP  ? (imm ? EXECUTEI : EXECUTER) : UNKNOWN;
            MEMADR:             nxt = ld ? MEMRD : MEMWR;
            MEMRD:              nxt = MEMWB;
            EXECUTER, EXECUTEI: nxt = ALUWB;
            default:            nxt = FETCH;
        endcase
    end

    // ctrl always tracks state so outputs stay a pure function of the state register
    always_ff @(posedge clk) begin
        state <= rst ? FETCH : nxt;
        ctrl  <= state_ctrl(rst ? FETCH : nxt);
    end
endmodule

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle control unit; ALU decode, PCS and reset gating around the main FSM
module mc_decoder
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         reset,
    mc_decoder_if.master bus
);
    ctrl_t      fsm_c, c;
    logic [3:0] cmd;
    logic       known, dec;

    mc_main_fsm u_fsm (
        .clk  (clk),
        .rst  (reset),
        .op   (bus.Op),
        .imm  (bus.Funct[5]),
        .ld   (bus.Funct[0]),
        .ctrl (fsm_c)
    );

    // during reset the selects look like FETCH but no write strobe escapes
    always_comb begin
        c         = reset ? state_ctrl(FETCH) : fsm_c;
        c.irwrite = c.irwrite & ~reset;
        c.nextpc  = c.nextpc & ~reset;
    end

    assign cmd   = bus.Funct[4:1];
    assign known = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND || cmd == CMD_ORR;
    assign dec   = c.aluop && known;

    assign bus.ALUControl = !dec ? ALU_ADD :
                            cmd == CMD_SUB ? ALU_SUB :
                            cmd == CMD_AND ? ALU_AND :
                            cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
    assign bus.FlagW      = dec ? {bus.Funct[0], bus.Funct[0] & (cmd == CMD_ADD || cmd == CMD_SUB)} : 2'b00;
    assign bus.RegW       = c.regw;
    assign bus.MemW       = c.memw;
    assign bus.PCS        = (bus.Rd == 4'd15 && c.regw) || c.branch;
    assign bus.IRWrite    = c.irwrite;
    assign bus.NextPC     = c.nextpc;
    assign bus.AdrSrc     = c.adrsrc;
    assign bus.ResultSrc  = c.resultsrc;
    assign bus.ALUSrcA    = c.alusrca;
    assign bus.ALUSrcB    = c.alusrcb;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
endmodule
